fetch_unit: RTL



---
 rtl/fetch_unit.sv | 90 +++++++++
 1 files changed

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, issues byte reads to main memory
// and buffers returned bytes in a prefetch FIFO for decode.
module fetch_unit #(
  parameter int          FIFO_DEPTH = 4,
  parameter logic [15:0] RESET_PC   = 16'h0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [15:0] Addr,
  output logic        fetch_req,
  input  logic        bus_grant,
  input  logic [7:0]  MemDataOut,
  input  logic        jmp,
  input  logic [15:0] jmp_addr,
  output logic [7:0]  ir_data,
  output logic [15:0] ir_pc,
  output logic        ir_valid,
  input  logic        ir_ready
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

  logic [15:0]   pc;
  logic [15:0]   head_pc;
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic [CW-1:0] count;
  logic          inflight;
  logic [7:0]    fifo_mem [FIFO_DEPTH];

  logic          push;
  logic          pop;
  logic [CW-1:0] credit;

  // An in-flight read already owns a slot; a same-cycle pop is not credited.
  assign credit    = count + CW'(inflight);
  assign fetch_req = rst_n & bus_grant & ~jmp & (credit < DEPTH_C);

  assign push = inflight & ~jmp;
  assign pop  = ir_valid & ir_ready & ~jmp;

  assign Addr     = pc;
  assign ir_valid = (count != '0);
  assign ir_data  = ir_valid ? fifo_mem[rd_ptr] : 8'h00;
  assign ir_pc    = head_pc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc       <= RESET_PC;
      head_pc  <= RESET_PC;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      inflight <= 1'b0;
    end else if (jmp) begin
      pc       <= jmp_addr;
      head_pc  <= jmp_addr;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      inflight <= 1'b0;
    end else begin
      if (fetch_req) begin
        pc <= pc + 16'd1;
      end
      inflight <= fetch_req;
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr  <= rd_ptr + AW'(1);
        head_pc <= head_pc + 16'd1;
      end
      unique case (1'b1)
        push & ~pop: count <= count + CW'(1);
        pop & ~push: count <= count - CW'(1);
        default:     count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr] <= MemDataOut;
    end
  end

endmodule
